spi_target: RTL and testbench
=============================

// Module: spi_target
// PURPOSE
//  SPI target (responder), mode 0 (CPOL=0, CPHA=0), one byte per frame slot, MSB first by default.
//  Counterpart of the SoC SPI master (spi_clk_o/spi_cs_o/spi_mosi_o/spi_miso_i).
//  Oversamples SCK, CS and MOSI on the system clock. Exposes valid/ready byte streams to a local host.
//  Used as an on-chip peripheral model and in SoC loopback benches.
// PARAMETERS
//  DATA_W    8      bits per SPI word
//  DUMMY_TX  8'hFF  word shifted out when the tx holding register is empty
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous reset, active-low
//  spi_clk_i    in   1       SCK from master (asynchronous to clk)
//  spi_cs_i     in   1       chip select, active-low (asynchronous)
//  spi_mosi_i   in   1       master-out data
//  spi_miso_o   out  1       target-out data; 1 while deselected
//  tx_data_i    in   DATA_W  next word to return to the master
//  tx_valid_i   in   1       tx_data_i valid
//  tx_ready_o   out  1       tx holding register empty; accepts when valid&ready
//  rx_data_o    out  DATA_W  last word received
//  rx_valid_o   out  1       rx_data_o valid; held until rx_ready_i
//  rx_ready_i   in   1       host consumes rx word
//  overrun_o    out  1       1-cycle pulse: word completed while rx_valid_o still high (new word dropped)
// BEHAVIOUR
//  - Reset values: spi_miso_o=1, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, overrun_o=0.
//    Reset also clears the shift register, the bit counter and state=IDLE.
//  - Synchronisation: SCK, CS and MOSI each pass a 2-flop synchroniser plus an edge register.
//    All decisions use the synchronised signals.
//  - SCK timing: SCK high and low must each last at least 4 clk cycles.
//    From CS fall to the first SCK rise: at least 4 clk cycles.
//  - FSM states IDLE and SHIFT.
//    IDLE -> SHIFT on the synced CS falling edge.
//      On entry, shift_reg <= tx holding word if full, otherwise DUMMY_TX. Holding register is freed (tx_ready_o=1 next cycle).
//      bit_cnt <= 0. spi_miso_o <= shift_reg MSB.
//    SHIFT, synced SCK rise: sample MOSI into the rx shifter; bit_cnt++.
//    SHIFT, synced SCK fall: shift tx; spi_miso_o <= next bit.
//      If bit_cnt==DATA_W (word boundary), instead reload from holding/DUMMY_TX, free holding, bit_cnt <= 0.
//    SHIFT -> IDLE on the synced CS rising edge.
//  - Word complete: the DATA_W-th SCK rise.
//    If rx_valid_o==0: rx_data_o <= rx word and rx_valid_o <= 1 on the next clk.
//    Otherwise: overrun_o pulses and rx_data_o is unchanged.
//  - rx_valid_o clears on rx_valid_o & rx_ready_i.
//    If completion and consume happen in the same cycle, the new word is loaded and rx_valid_o stays 1; no overrun.
//  - tx: a host write while tx_ready_o=1 fills the holding register.
//    A write and a reload in the same cycle: the reload takes the OLD holding word, the new word is stored, tx_ready_o=0.
//  - CS rises mid-word: partial rx bits are discarded, no rx_valid, bit_cnt <= 0, spi_miso_o <= 1.
//    The partial tx word is lost; the holding register is kept.
//  - CS low with no SCK: spi_miso_o holds its current bit indefinitely.
//  - bit_cnt width is $clog2(DATA_W+1). Wrap-around is prevented by the word-boundary reload.
// CONFIGURATION
//  SPI_TARGET_LSB_FIRST_EN
//    Defined: rx and tx are LSB first (shift right; spi_miso_o = shift_reg[0]).
//    Undefined (default): MSB first.
// STRUCTURE
//  - Package spi_pkg: typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_e; localparam SPI_SYNC_STAGES=2.
//  - Sub-module spi_sync: 2-flop synchroniser plus rise/fall pulse outputs.
//    Reset value is a parameter (1 for CS, 0 for SCK and MOSI). Instantiated 3 times.
//  - The FSM, shifters and the tx/rx holding registers live in spi_target.
// TESTING
//  1 Reset: rst_n=0 mid-frame -> miso=1, tx_ready=1, rx_valid=0 immediately (async); FSM=IDLE after release.
//  2 tx 8'hA5 loaded, master sends 8'h3C, SCK period 10 clk -> master reads A5; rx_data=3C, rx_valid=1 until rx_ready.
//  3 No tx loaded, master sends 8'h81 -> master reads FF; rx_data=81.
//  4 Two back-to-back words 8'h11, 8'h22 with rx_ready=0 -> rx_data=11, overrun pulses once, 22 dropped.
//  5 CS raised after 5 SCK rises -> no rx_valid, miso=1; next full frame with tx 8'h5A returns 5A.
//  6 SPI_TARGET_LSB_FIRST_EN defined, tx 8'h01, master sends 8'h80 LSB-first -> first miso bit 1; rx_data=80.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target.
// Holds the FSM state encoding and the synchroniser depth.
// Bit order is chosen per build with SPI_TARGET_LSB_FIRST_EN (default MSB first).
package spi_pkg;

  typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_e;

  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_target_if.sv
// Host-side byte streams of the SPI target: tx holding-register write and rx word read.
// Both directions use valid/ready; overrun_o flags a received word that was dropped.
// The target uses the slave modport, the local host the master modport.
interface spi_target_if #(parameter int DATA_W = 8) ();

  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ready_i;
  logic              overrun_o;

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, rx_data_o, rx_valid_o, overrun_o
  );

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, overrun_o
  );

endinterface

// File: rtl/spi_sync.sv
// Brings one asynchronous SPI pin into the clk domain and flags its edges.
// Latency: SPI_SYNC_STAGES cycles to q, rise/fall pulse in the same cycle q changes.
// No backpressure; rise/fall are single-cycle pulses.
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync;
  logic                       prev;

  // Synchroniser chain plus one edge register holding the previous synced value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SPI_SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[SPI_SYNC_STAGES-2:0], d};
      prev <= sync[SPI_SYNC_STAGES-1];
    end
  end

  assign q    = sync[SPI_SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCK/CS/MOSI, one DATA_W word per slot, tx/rx byte streams to host.
// Latency: rx word visible the clk after the synced last SCK rise; MISO updates ~3 clk after SCK fall.
// Backpressure: a word completing while rx_valid_o is high is dropped and overrun_o pulses.
// Build option SPI_TARGET_LSB_FIRST_EN selects LSB-first shifting (default MSB first).
module spi_target
  import spi_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] DUMMY_TX = {DATA_W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         spi_clk_i,
  input  logic         spi_cs_i,
  input  logic         spi_mosi_i,
  output logic         spi_miso_o,
  spi_target_if.slave  host
);

  localparam int CW = $clog2(DATA_W + 1);

  spi_state_e        state, state_nxt;
  logic              sck_q, sck_rise, sck_fall;
  logic              cs_q, cs_rise, cs_fall;
  logic              mosi_q, mosi_rise, mosi_fall;
  logic [DATA_W-1:0] shift_tx, shift_rx, hold_dat, load_word, tx_next, rx_next, rx_dat;
  logic [CW-1:0]     bit_cnt;
  logic              hold_full, wr, entry, abort, bit_rise, bit_fall;
  logic              word_done, word_end, load, rx_vld, overrun;
  logic              unused_sync;

  spi_sync #(.RST_VAL(1'b0)) u_sck  (.clk(clk), .rst_n(rst_n), .d(spi_clk_i),
                                     .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_sync #(.RST_VAL(1'b1)) u_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_i),
                                     .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi_i),
                                     .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_sync = ^{sck_q, cs_q, mosi_rise, mosi_fall};

  // Bit on the wire for a given tx word (first bit to go out in the chosen order).
  function automatic logic out_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_TARGET_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

`ifdef SPI_TARGET_LSB_FIRST_EN
  assign tx_next = {1'b0, shift_tx[DATA_W-1:1]};
  assign rx_next = {mosi_q, shift_rx[DATA_W-1:1]};
`else
  assign tx_next = {shift_tx[DATA_W-2:0], 1'b0};
  assign rx_next = {shift_rx[DATA_W-2:0], mosi_q};
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SPI_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle frame events; SCK edges only count while selected.
  always_comb begin
    state_nxt = state;
    entry     = 1'b0;
    abort     = 1'b0;
    bit_rise  = 1'b0;
    bit_fall  = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (cs_fall) begin
          state_nxt = SPI_SHIFT;
          entry     = 1'b1;
        end
      end
      SPI_SHIFT: begin
        if (cs_rise) begin
          state_nxt = SPI_IDLE;
          abort     = 1'b1;
        end else begin
          bit_rise = sck_rise;
          bit_fall = sck_fall;
        end
      end
      default: state_nxt = SPI_IDLE;
    endcase
  end

  assign word_done = bit_rise && (bit_cnt == CW'(DATA_W - 1));
  assign word_end  = bit_fall && (bit_cnt == CW'(DATA_W));
  assign load      = entry | word_end;
  assign wr        = host.tx_valid_i & ~hold_full;
  // A reload always sees the holding word from before this cycle's host write.
  assign load_word = hold_full ? hold_dat : DUMMY_TX;

  // tx holding register: filled by the host, emptied by every slot load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_dat  <= '0;
      hold_full <= 1'b0;
    end else begin
      if (wr) hold_dat <= host.tx_data_i;
      hold_full <= (hold_full & ~load) | wr;
    end
  end

  // Shifters, bit counter and MISO; MISO idles high and holds while SCK is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_tx   <= '0;
      shift_rx   <= '0;
      bit_cnt    <= '0;
      spi_miso_o <= 1'b1;
    end else if (entry) begin
      shift_tx   <= load_word;
      shift_rx   <= '0;
      bit_cnt    <= '0;
      spi_miso_o <= out_bit(load_word);
    end else if (abort) begin
      bit_cnt    <= '0;
      spi_miso_o <= 1'b1;
    end else if (bit_rise) begin
      shift_rx <= rx_next;
      bit_cnt  <= bit_cnt + CW'(1);
    end else if (word_end) begin
      shift_tx   <= load_word;
      bit_cnt    <= '0;
      spi_miso_o <= out_bit(load_word);
    end else if (bit_fall) begin
      shift_tx   <= tx_next;
      spi_miso_o <= out_bit(tx_next);
    end
  end

  // rx word register: load when free or being consumed this cycle, otherwise flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_dat  <= '0;
      rx_vld  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done && (!rx_vld || host.rx_ready_i)) begin
        rx_dat <= rx_next;
        rx_vld <= 1'b1;
      end else if (word_done) begin
        overrun <= 1'b1;
      end else if (rx_vld && host.rx_ready_i) begin
        rx_vld <= 1'b0;
      end
    end
  end

  assign host.tx_ready_o = ~hold_full;
  assign host.rx_data_o  = rx_dat;
  assign host.rx_valid_o = rx_vld;
  assign host.overrun_o  = overrun;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-banged SPI master plus host streams, checked against a word-level model.
// Model: each word slot (CS fall, and the end of every word) takes the pending host word or 8'hFF;
// each completed word lands in rx if rx is free, otherwise counts one overrun.
module tb_spi_target;
  import spi_pkg::*;

`ifdef SPI_TARGET_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic miso;

  spi_target_if #(.DATA_W(8)) host_if ();

  spi_target #(.DATA_W(8), .DUMMY_TX(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk_i(sck), .spi_cs_i(cs),
    .spi_mosi_i(mosi), .spi_miso_o(miso), .host(host_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int ovr_cnt = 0;

  // Overrun pulse counter, sampled away from the active edge.
  always @(negedge clk) if (host_if.overrun_o === 1'b1) ovr_cnt++;

  // Reference model state.
  logic [7:0] tx_q[$];
  logic [7:0] cur_tx;
  logic [7:0] exp_rx = 8'h00;
  logic       exp_vld = 1'b0;
  int         exp_ovr = 0;
  logic       last_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_pop();
    if (tx_q.size() > 0) return tx_q.pop_front();
    return 8'hFF;
  endfunction

  task automatic host_write(input logic [7:0] w);
    host_if.tx_data_i  = w;
    host_if.tx_valid_i = 1'b1;
    @(negedge clk);
    host_if.tx_valid_i = 1'b0;
    tx_q.push_back(w);
  endtask

  task automatic pulse();
    sck = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // One word, SCK period 10 clk; master samples MISO just before each rise.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic first);
    logic b;
    rx = 8'h00;
    first = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mosi = LSB ? tx[k] : tx[7-k];
      repeat (5) @(negedge clk);
      b = miso;
      if (k == 0) first = b;
      rx = LSB ? {b, rx[7:1]} : {rx[6:0], b};
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    cur_tx = model_pop();
    repeat (8) @(negedge clk);
  endtask

  task automatic word(input logic [7:0] m, input string tag);
    logic [7:0] r;
    logic       f;
    xfer(m, r, f);
    check({tag, "_miso_word"}, {24'h0, r}, {24'h0, cur_tx});
    last_first = f;
    if (!exp_vld) begin
      exp_vld = 1'b1;
      exp_rx  = m;
    end else begin
      exp_ovr++;
    end
    cur_tx = model_pop();
  endtask

  task automatic cs_high();
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rx_valid"}, {31'h0, host_if.rx_valid_o}, {31'h0, exp_vld});
    check({tag, "_rx_data"}, {24'h0, host_if.rx_data_o}, {24'h0, exp_rx});
    check({tag, "_overruns"}, ovr_cnt, exp_ovr);
    check({tag, "_miso_idle"}, {31'h0, miso}, 32'h1);
  endtask

  task automatic consume(input string tag);
    host_if.rx_ready_i = 1'b1;
    @(negedge clk);
    host_if.rx_ready_i = 1'b0;
    exp_vld = 1'b0;
    check({tag, "_rx_consumed"}, {31'h0, host_if.rx_valid_o}, 32'h0);
  endtask

  initial begin
    logic [7:0] w;
    int n;
    host_if.tx_data_i  = 8'h00;
    host_if.tx_valid_i = 1'b0;
    host_if.rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_miso", {31'h0, miso}, 32'h1);
    check("rst_tx_ready", {31'h0, host_if.tx_ready_o}, 32'h1);
    check("rst_rx_valid", {31'h0, host_if.rx_valid_o}, 32'h0);
    check("rst_rx_data", {24'h0, host_if.rx_data_o}, 32'h0);
    check("rst_overrun", {31'h0, host_if.overrun_o}, 32'h0);

    // Asynchronous reset in the middle of a frame.
    host_write(8'h00);
    cs_low();
    pulse();
    pulse();
    check("mid_miso_low", {31'h0, miso}, 32'h0);
    host_write(8'h42);
    check("mid_tx_full", {31'h0, host_if.tx_ready_o}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("arst_miso", {31'h0, miso}, 32'h1);
    check("arst_tx_ready", {31'h0, host_if.tx_ready_o}, 32'h1);
    check("arst_rx_valid", {31'h0, host_if.rx_valid_o}, 32'h0);
    cs = 1'b1;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_fsm_idle", {31'h0, dut.state}, {31'h0, SPI_IDLE});
    tx_q.delete();

    // Loaded tx word returned; rx word held until consumed.
    host_write(8'hA5);
    cs_low();
    word(8'h3C, "t2");
    cs_high();
    check_rx("t2");
    repeat (10) @(negedge clk);
    check("t2_rx_held", {31'h0, host_if.rx_valid_o}, 32'h1);
    consume("t2");

    // Empty holding register gives the dummy word.
    cs_low();
    word(8'h81, "t3");
    cs_high();
    check_rx("t3");
    consume("t3");

    // Back-to-back words, rx not consumed: second word dropped with one overrun.
    // A write during word 1 is reloaded at the word boundary.
    host_write(8'h77);
    cs_low();
    check("t4_tx_freed", {31'h0, host_if.tx_ready_o}, 32'h1);
    host_write(8'h99);
    word(8'h11, "t4w1");
    word(8'h22, "t4w2");
    cs_high();
    check_rx("t4");
    consume("t4");

    // Frame aborted after 5 SCK rises, then a full frame with a loaded word.
    cs_low();
    for (int i = 0; i < 5; i++) pulse();
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_no_rx", {31'h0, host_if.rx_valid_o}, 32'h0);
    check("t5_miso_idle", {31'h0, miso}, 32'h1);
    host_write(8'h5A);
    cs_low();
    word(8'($urandom), "t5");
    cs_high();
    check_rx("t5");
    consume("t5");

    // Bit order: first bit out of 8'h01 is its LSB or MSB depending on build.
    host_write(8'h01);
    cs_low();
    word(8'h80, "t6");
    check("t6_first_bit", {31'h0, last_first}, LSB ? 32'h1 : 32'h0);
    cs_high();
    check_rx("t6");
    consume("t6");

    // Randomized frames of one or two words, with or without a loaded tx word.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(1, 0) == 1) host_write(8'($urandom));
      cs_low();
      n = $urandom_range(2, 1);
      for (int j = 0; j < n; j++) begin
        w = 8'($urandom);
        word(w, "rnd");
      end
      cs_high();
      check_rx("rnd");
      consume("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
